// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART port:
//   DATA_BITS          - payload bits per frame (8N1 framing)
//   tx_state_e         - transmit FSM states
//   rx_state_e         - receive FSM states
//   calc_clks_per_bit  - integer clocks per bit from clock and line rates
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    // Truncating division: the residual baud error is accepted.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO.
//   clock, reset : clock and synchronous active-high reset (empties the FIFO)
//   push, push_data : write request; ignored while full
//   pop, pop_data   : read request; pop_data shows the head whenever !empty
//   full, empty, count : status derived from the registered occupancy
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Both decisions use the occupancy registered at the start of the cycle,
    // so a push into a full FIFO is dropped even if a pop happens alongside.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_q;

    // Asynchronous read keeps the head visible without a pop cycle.
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_fifo_port.sv
// -----------------------------------------------------------------------------
// uart_fifo_port
// 8N1 UART with receive and transmit FIFOs and sticky error flags.
//   clock, reset        : system clock, synchronous active-high reset
//   rx / tx             : serial pins (idle high); rx is asynchronous
//   tx_data/valid/ready : enqueue bytes for transmission
//   rx_data/valid/ready : first-word-fall-through receive queue head / pop
//   rx_count, tx_count  : FIFO occupancies
//   tx_busy             : transmitter active or bytes still queued
//   rx_overflow         : sticky, a received byte was dropped (rx FIFO full)
//   frame_error         : sticky, a stop bit was sampled low
//   clear_errors        : clears both sticky flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module uart_fifo_port
    import uart_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int BAUD     = 115200,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            rx,
    output logic                            tx,
    input  logic [7:0]                      tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic [7:0]                      rx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic [$clog2(RX_DEPTH+1)-1:0]   rx_count,
    output logic [$clog2(TX_DEPTH+1)-1:0]   tx_count,
    output logic                            tx_busy,
    output logic                            rx_overflow,
    output logic                            frame_error,
    input  logic                            clear_errors
);

    localparam int CPB   = calc_clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);
    localparam int BIT_W = $clog2(DATA_BITS);

    // ------------------------------------------------------------------ TX
    tx_state_e              tx_state_q, tx_state_d;
    logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]       tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_q, tx_d;
    logic                   tx_pop;
    logic                   tx_full, tx_empty;
    logic [DATA_BITS-1:0]   tx_head;
    logic                   tx_bit_end;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    assign tx_ready   = !tx_full;
    assign tx_busy    = (tx_state_q != TX_IDLE) || !tx_empty;
    assign tx_bit_end = (tx_cnt_q == CNT_W'(CPB-1));
    assign tx         = tx_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + CNT_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + BIT_W'(1);
                    if (tx_bit_q == BIT_W'(DATA_BITS-1)) begin
                        tx_state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                // Chain straight into the next queued byte: no idle bit-time.
                if (tx_bit_end) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Line level follows the current state one cycle later, glitch-free.
        case (tx_state_q)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    // ------------------------------------------------------------------ RX
    rx_state_e              rx_state_q, rx_state_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_meta_q, rx_sync_q;
    logic                   rx_push;
    logic                   rx_full, rx_empty;
    logic                   ovf_set, ferr_set;
    logic                   rx_overflow_q, rx_overflow_d;
    logic                   frame_error_q, frame_error_d;
    logic                   rx_bit_end, rx_half;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_shift_q),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    assign rx_valid    = !rx_empty;
    assign rx_overflow = rx_overflow_q;
    assign frame_error = frame_error_q;
    assign rx_bit_end  = (rx_cnt_q == CNT_W'(CPB-1));
    assign rx_half     = (rx_cnt_q == CNT_W'(HALF-1));

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        ovf_set    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Half a bit in: still low means a real start bit, and every
                // later sample lands at mid-bit.
                if (rx_half) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + BIT_W'(1);
                    if (rx_bit_q == BIT_W'(DATA_BITS-1)) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_push    = !rx_full;
                        ovf_set    = rx_full;
                        rx_state_d = RX_IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        rx_state_d = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                // A held-low line (break) must not be decoded as endless frames.
                rx_cnt_d = '0;
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        rx_overflow_d = ovf_set  | (rx_overflow_q & ~clear_errors);
        frame_error_d = ferr_set | (frame_error_q & ~clear_errors);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_overflow_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_meta_q     <= rx;
            rx_sync_q     <= rx_meta_q;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_overflow_q <= rx_overflow_d;
            frame_error_q <= frame_error_d;
        end
    end

endmodule

// File: doc/uart_fifo_port.md
Name: uart_fifo_port

Overview:
Parametrised UART with independent receive and transmit FIFOs. It replaces the bare uart_rx/uart_tx pair and per-board baud constants in the board frameworks. Baud divisor is derived from clock frequency and baud rate. Sits between the board serial pins and M_main's uart_* handshake ports, adding buffering and sticky error reporting so the CPU can tolerate burst traffic.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 4)
RX_DEPTH, 16, receive FIFO entries; power of two, >= 2
TX_DEPTH, 16, transmit FIFO entries; power of two, >= 2

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
rx  in  1  serial input from pin; asynchronous, idle high
tx  out  1  serial output to pin; idle high
tx_data  in  8  byte to enqueue
tx_valid  in  1  enqueue request
tx_ready  out  1  tx FIFO not full
rx_data  out  8  head of rx FIFO (first-word fall-through)
rx_valid  out  1  rx FIFO not empty
rx_ready  in  1  pop request
rx_count  out  clog2(RX_DEPTH+1)  rx FIFO occupancy
tx_count  out  clog2(TX_DEPTH+1)  tx FIFO occupancy
tx_busy  out  1  tx FSM not idle or tx FIFO non-empty
rx_overflow  out  1  sticky: byte dropped because rx FIFO full
frame_error  out  1  sticky: stop bit sampled low
clear_errors  in  1  clears both sticky flags

Behaviour:
- Reset: tx=1, tx_ready=1, rx_valid=0, counts=0, tx_busy=0, flags=0, FSMs IDLE, FIFOs emptied, synchroniser preset to 1. Reset mid-frame aborts the frame; tx is high on the cycle after reset is sampled.
- Frame: 8N1, LSB first.
- TX push: on tx_valid && tx_ready. While full, tx_ready=0 and data is ignored.
- TX FSM states: IDLE, START, DATA(8 bits), STOP, each 1 bit-time except DATA (8). IDLE with FIFO non-empty pops the head, and tx is low exactly 2 cycles after the accepting edge into an empty, idle port. After STOP, the next queued byte starts with no idle gap. tx is driven from a register.
- RX sync: rx passes through a 2-flop synchroniser before any use.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE to START on synced low.
  - START re-samples at CLKS_PER_BIT/2; if high, it is a glitch and the FSM returns to IDLE.
  - DATA samples every CLKS_PER_BIT at mid-bit.
  - STOP sample high: push the byte (or set rx_overflow and drop it if full), then go to IDLE.
  - STOP sample low: set frame_error, discard the byte, go to WAIT_HIGH until synced rx=1. This prevents break conditions from flooding the FIFO.
- RX FIFO: rx_data is valid combinationally whenever rx_valid=1. Pop on rx_valid && rx_ready. A write and a pop in the same cycle are both honoured and the count is unchanged. A full FIFO with a simultaneous pop still drops the incoming byte; the write decision uses pre-pop occupancy.
- Counters: FIFO pointers are clog2(DEPTH) bits and wrap naturally. Count is the registered occupancy.
- Flags: clear_errors clears the flags next cycle. If a new error occurs in the same cycle as clear_errors, the set wins.

Decomposition:
- Shared package uart_pkg: frame constants (DATA_BITS=8), rx/tx state enums, and a function computing CLKS_PER_BIT.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; FWFT; ports push/pop/full/empty/count), instantiated for both rx and tx.
- The rx and tx FSMs stay in the top module.

Test Plan (CLK_HZ=1000000, BAUD=100000, so 10 clocks/bit):
- Push 0xA5 into an idle port: tx is low 2 cycles later, then bits 1,0,1,0,0,1,0,1 at 10-cycle spacing, stop high; tx_busy drops after the stop bit; total 100 cycles.
- Push 17 bytes back-to-back with TX_DEPTH=16 while transmitting: tx_ready deasserts at the correct occupancy; frames are contiguous with no gap; all bytes are emitted in order.
- Drive 0x3C then 0xFF serially on rx: rx_valid rises after the stop sample; rx_data=0x3C, then 0xFF after pop; rx_count goes 1, 2, 1, 0.
- Send 17 frames without popping (RX_DEPTH=16): the 17th sets rx_overflow; FIFO holds the first 16 bytes; clear_errors resets the flag.
- Frame with low stop bit, then rx held low for 50 cycles: frame_error=1, no push, no further frames until rx returns high; a 3-cycle low glitch produces no byte.
- Assert reset mid-transmit and mid-receive: tx=1 the next cycle; counts=0, rx_valid=0, flags=0; a following frame is received correctly.
